// File: rtl/div_iterative.sv
// rtl/div_iterative.sv - radix-2 restoring sequential divider (div/divu) for the HI/LO path
module div_iterative #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             out_valid,
   output logic             stall
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   prem_q;      // partial remainder, one guard bit for the trial sign
   logic [WIDTH-1:0] quo_q;       // dividend magnitude shifts out the top, quotient bits shift in
   logic [WIDTH-1:0] dvs_q;       // divisor magnitude
   logic [WIDTH-1:0] orig_q;      // raw dividend, returned as remainder on divide-by-zero
   logic             q_neg_q;
   logic             r_neg_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             out_valid_q;

   logic             dvd_neg_d;
   logic             dvs_neg_d;
   logic [WIDTH-1:0] dvd_mag_d;
   logic [WIDTH-1:0] dvs_mag_d;
   logic [WIDTH:0]   shifted_d;
   logic [WIDTH:0]   trial_d;
   logic [WIDTH:0]   prem_d;
   logic [WIDTH-1:0] quo_d;
   logic [WIDTH-1:0] q_fix_d;
   logic [WIDTH-1:0] r_fix_d;

   // Operand magnitudes, one restoring step, and the sign/zero fix-up of the final result
   always_comb begin
      dvd_neg_d = is_signed & dividend[WIDTH-1];
      dvs_neg_d = is_signed & divisor[WIDTH-1];
      dvd_mag_d = dvd_neg_d ? -dividend : dividend;
      dvs_mag_d = dvs_neg_d ? -divisor : divisor;

      shifted_d = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      trial_d   = shifted_d - {1'b0, dvs_q};
      if (trial_d[WIDTH]) begin
         prem_d = shifted_d;
         quo_d  = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
         prem_d = trial_d;
         quo_d  = {quo_q[WIDTH-2:0], 1'b1};
      end

      q_fix_d = q_neg_q ? -quo_q : quo_q;
      r_fix_d = r_neg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
      if (dvs_q == '0) begin
         q_fix_d = '1;
         r_fix_d = orig_q;
      end
   end

   // Control FSM with datapath registers and registered result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         prem_q      <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         orig_q      <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               out_valid_q <= 1'b0;
               if (in_valid) begin
                  quo_q   <= dvd_mag_d;
                  dvs_q   <= dvs_mag_d;
                  orig_q  <= dividend;
                  q_neg_q <= dvd_neg_d ^ dvs_neg_d;
                  r_neg_q <= dvd_neg_d;
                  prem_q  <= '0;
                  cnt_q   <= '0;
                  state_q <= S_DIV;
               end
            end
            S_DIV: begin
               prem_q <= prem_d;
               quo_q  <= quo_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               quotient_q  <= q_fix_d;
               remainder_q <= r_fix_d;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               out_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   // Hold the pipeline from the accepting cycle until the result is ready
   always_comb begin
      stall = ((state_q == S_IDLE) && in_valid) || (state_q == S_DIV) || (state_q == S_FIX);
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign out_valid = out_valid_q;

endmodule

// File: doc/div_iterative.md
# div_iterative

Sequential 32-bit integer divider for the MultDiv extension; the counterpart of the Booth multiplier on the HI/LO path. It accepts a dividend/divisor pair under the same `in_valid`/`stall`/`out_valid` handshake the processor already uses for multiplication. It computes quotient (LO) and remainder (HI) one bit per cycle with a radix-2 restoring algorithm. Signed operation uses truncating MIPS `div` semantics; unsigned operation matches `divu`.

## Interface
- `WIDTH`, 32, operand and result width; iteration count equals `WIDTH`
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operands valid; accepted only in IDLE
- `is_signed`  in  1  1 = two's-complement `div`, 0 = `divu`; captured with operands
- `dividend`  in  WIDTH  numerator
- `divisor`  in  WIDTH  denominator
- `quotient`  out  WIDTH  registered quotient (LO)
- `remainder`  out  WIDTH  registered remainder (HI)
- `out_valid`  out  1  result valid, one-cycle pulse
- `stall`  out  1  processor must hold pipeline

## Operation
- States:
  - IDLE: go to DIV on `in_valid`.
  - DIV: runs exactly WIDTH cycles, then goes to FIX.
  - FIX: one cycle, then goes to DONE.
  - DONE: one cycle, then goes to IDLE.
- Capture on acceptance edge:
  - In signed mode, operands are converted to magnitudes.
  - Record `q_neg = sign(dividend) XOR sign(divisor)` and `r_neg = sign(dividend)`.
  - Clear the WIDTH+1-bit partial remainder and the iteration counter.
- DIV iteration:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Compute trial = partial remainder − divisor magnitude, using WIDTH+1 bits.
  - If trial ≥ 0, the partial remainder becomes trial and the quotient LSB is 1; otherwise it is restored and the LSB is 0.
  - The counter increments each iteration.
- FIX: apply sign correction, then load the `quotient`/`remainder` output registers.
  - Quotient is negated if `q_neg`.
  - Remainder is negated if `r_neg`, so the remainder takes the dividend's sign.
- Divisor zero (both modes):
  - `quotient` = all ones and `remainder` = original dividend, forced in FIX.
  - Latency is unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): `quotient` = 0x80000000, `remainder` = 0. This is the natural result of magnitude math plus negation; no special case is required, but it must hold.
- `in_valid` in DIV, FIX or DONE is ignored. Operands are not re-captured and no queueing occurs.
- Outputs hold the last result until the next FIX overwrites them.

## Timing
- Reset:
  - Applies immediately, regardless of clock.
  - State returns to IDLE; counter, internal registers, `quotient` and `remainder` go to 0.
  - `out_valid` = 0; `stall` = 0 while IDLE and `in_valid` is low.
- Reset mid-operation aborts the division. No `out_valid` is produced for the aborted operation.
- Acceptance edge E0: state is IDLE and `in_valid` = 1.
  - DIV occupies the cycles after edges E0..E(WIDTH−1).
  - FIX follows E(WIDTH); DONE follows E(WIDTH+1).
- `out_valid` = 1 only in DONE: exactly WIDTH+2 cycles after the in_valid cycle (34 for WIDTH=32).
  - Results are stable in the same cycle and held afterwards.
- `stall` (combinational from state and `in_valid`):
  - 1 when (IDLE and `in_valid`), or in DIV or FIX.
  - 0 in DONE, and 0 in IDLE without `in_valid`.
- Back-to-back operation: DONE always returns to IDLE. A new `in_valid` in the DONE cycle is ignored; the next acceptance is earliest one cycle after DONE.

## Test plan
- Unsigned 100 / 7 (`is_signed` = 0) -> `quotient` = 14, `remainder` = 2.
  - `out_valid` is high in cycle 34 only.
  - `stall` = 1 in cycles 0–33 and 0 in cycle 34.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) -> `quotient` = 0xFFFFFFFD, `remainder` = 0xFFFFFFFF.
- Signed 7 / −2 -> `quotient` = 0xFFFFFFFD, `remainder` = 1.
- Unsigned 0xFFFFFFFF / 1 -> `quotient` = 0xFFFFFFFF, `remainder` = 0.
- Divisor zero with dividend 0x12345678 (both modes) -> `quotient` = 0xFFFFFFFF, `remainder` = 0x12345678, at the same 34-cycle latency.
- Signed 0x80000000 / 0xFFFFFFFF -> `quotient` = 0x80000000, `remainder` = 0.
- Robustness: pulse `in_valid` with new operands at cycle 10 -> ignored, and the first result is unchanged.
  - Then assert `rst` asynchronously mid-DIV -> outputs go to 0 immediately, with no `out_valid`.
  - A fresh operation after reset completes normally.
